// File: rtl/icache_fetch_ctrl_if.sv
// Fetch, cache and memory-side signals of the instruction-cache miss controller.
// master = the controller, slave = fetch unit / cache array / memory controller.
interface icache_fetch_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              fetch_valid;
  logic [ADDR_W-1:0] fetch_pc;
  logic              inst_valid;
  logic [31:0]       inst;
  logic              cache_wr;
  logic [ADDR_W-1:0] cache_addr;
  logic [31:0]       cache_value;
  logic              cache_hit;
  logic [31:0]       cache_result;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_valid;
  logic [7:0]        mem_data;

  modport master (
    input  fetch_valid, fetch_pc, cache_hit, cache_result, mem_valid, mem_data,
    output inst_valid, inst, cache_wr, cache_addr, cache_value, mem_req, mem_addr
  );

  modport slave (
    output fetch_valid, fetch_pc, cache_hit, cache_result, mem_valid, mem_data,
    input  inst_valid, inst, cache_wr, cache_addr, cache_value, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_fetch_ctrl.sv
// Instruction-cache miss controller: hit return, 4-byte little-endian refill, cache write.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_fetch_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                flush,
  icache_fetch_ctrl_if.master bus,
  output logic                busy
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]         hit_cnt,
  output logic [31:0]         miss_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_HIT, S_FILL, S_DONE} state_t;

  state_t            state_reg, state_next;
  logic [1:0]        byte_cnt_reg, byte_cnt_next;
  logic [31:0]       fill_buf_reg, fill_buf_next;
  logic [31:0]       inst_reg, inst_next;
  logic [ADDR_W-1:0] pc_q_reg, pc_q_next;
  logic [ADDR_W-1:0] pc_aligned;

  assign pc_aligned = {bus.fetch_pc[ADDR_W-1:2], 2'b00};
  assign busy       = (state_reg != S_IDLE);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg <= S_IDLE;
    end else if (rdy_in) begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      byte_cnt_reg <= 2'd0;
      fill_buf_reg <= 32'd0;
      inst_reg     <= 32'd0;
      pc_q_reg     <= '0;
    end else if (rdy_in) begin
      byte_cnt_reg <= byte_cnt_next;
      fill_buf_reg <= fill_buf_next;
      inst_reg     <= inst_next;
      pc_q_reg     <= pc_q_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    byte_cnt_next   = byte_cnt_reg;
    fill_buf_next   = fill_buf_reg;
    inst_next       = inst_reg;
    pc_q_next       = pc_q_reg;
    bus.cache_addr  = pc_q_reg;
    bus.cache_wr    = 1'b0;
    bus.cache_value = fill_buf_reg;
    bus.inst_valid  = 1'b0;
    bus.inst        = inst_reg;
    bus.mem_req     = 1'b0;
    bus.mem_addr    = '0;

    case (state_reg)
      S_IDLE: begin
        bus.cache_addr = pc_aligned;
        if (bus.fetch_valid && !flush) begin
          pc_q_next     = pc_aligned;
          inst_next     = bus.cache_result;
          byte_cnt_next = 2'd0;
          state_next    = bus.cache_hit ? S_HIT : S_FILL;
        end
      end
      S_HIT: begin
        bus.inst_valid = rdy_in && !flush;
        state_next     = S_IDLE;
      end
      S_FILL: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = pc_q_reg + {{(ADDR_W-2){1'b0}}, byte_cnt_reg};
        if (bus.mem_valid) begin
          fill_buf_next[8*byte_cnt_reg +: 8] = bus.mem_data;
          byte_cnt_next = byte_cnt_reg + 2'd1;
          if (byte_cnt_reg == 2'd3) begin
            state_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        // Write-back and response share the cycle; both are suppressed by a stall or flush.
        bus.cache_wr   = rdy_in && !flush;
        bus.inst_valid = rdy_in && !flush;
        bus.inst       = fill_buf_reg;
        state_next     = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    // Redirect overrides everything, including a byte landing in the same cycle.
    if (flush) begin
      state_next    = S_IDLE;
      byte_cnt_next = 2'd0;
      fill_buf_next = fill_buf_reg;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_reg, miss_cnt_reg;
  logic        miss_event;

  assign miss_event = (state_reg == S_IDLE) && (state_next == S_FILL);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hit_cnt_reg  <= 32'd0;
      miss_cnt_reg <= 32'd0;
    end else if (rdy_in) begin
      if ((state_reg == S_HIT) && (hit_cnt_reg != 32'hFFFF_FFFF)) begin
        hit_cnt_reg <= hit_cnt_reg + 32'd1;
      end
      if (miss_event && (miss_cnt_reg != 32'hFFFF_FFFF)) begin
        miss_cnt_reg <= miss_cnt_reg + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_reg;
  assign miss_cnt = miss_cnt_reg;
`endif

endmodule
